// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and constants for the irq_pending_ctrl request stage.
package irq_pending_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        HOLD     = 2'd2
    } state_e;

    // Expand an encoder index into a one-hot channel vector.
    function automatic logic [NUM_CH-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_edge_capture.sv
// Rising-edge capture of the request lines into sticky pending bits.
// Optional overflow tracking when IRQ_PENDING_OVF_EN is defined.
module irq_edge_capture
    import irq_pending_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] clr,
    output logic [NUM_CH-1:0] pend_raw
`ifdef IRQ_PENDING_OVF_EN
    ,
    output logic [NUM_CH-1:0] ovf
`endif
);

    logic [NUM_CH-1:0] req_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] pend_d, pend_q;
`ifdef IRQ_PENDING_OVF_EN
    logic [NUM_CH-1:0] ovf_d, ovf_q;
`endif

    // Next pending state: a new edge wins over a same-cycle clear.
    always_comb begin
        rise   = req & ~req_q;
        pend_d = (pend_q & ~clr) | rise;
`ifdef IRQ_PENDING_OVF_EN
        // A re-edge on a bit that stays pending is a lost (merged) request.
        ovf_d  = (ovf_q & ~clr) | (rise & pend_q & ~clr);
`endif
    end

    // Register request history and pending state.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            pend_q <= '0;
`ifdef IRQ_PENDING_OVF_EN
            ovf_q  <= '0;
`endif
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
`ifdef IRQ_PENDING_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign pend_raw = pend_q;
`ifdef IRQ_PENDING_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt request stage: pending capture, masking, and host req/ack FSM
// with a programmable post-ack holdoff.
// Optional feature macro: IRQ_PENDING_OVF_EN (adds the ovf output).
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int HOLDOFF = 2,
    parameter int CW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [3:0]       pend,
    output logic             irq,
    output logic             busy
`ifdef IRQ_PENDING_OVF_EN
    ,
    output logic [3:0]       ovf
`endif
);

    state_e            state_d, state_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic              irq_q, busy_q;
    logic [NUM_CH-1:0] pend_raw;
    logic [NUM_CH-1:0] clr;

    irq_edge_capture u_capture (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .clr      (clr),
        .pend_raw (pend_raw)
`ifdef IRQ_PENDING_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    assign pend = pend_raw & ~mask;

    // Only an ack in WAIT_ACK naming a presented bit clears it.
    always_comb begin
        clr = '0;
        if (ack && state_q == WAIT_ACK) begin
            clr = idx_onehot(ack_idx) & pend;
        end
    end

    // Next-state and holdoff counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|pend) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack) begin
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CW'(HOLDOFF - 1);
                        state_d = HOLD;
                    end
                end else if (!(|pend)) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; irq/busy registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= (state_d == WAIT_ACK);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign irq  = irq_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl (HOLDOFF=2).
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic [3:0] pend;
    logic       irq;
    logic       busy;
`ifdef IRQ_PENDING_OVF_EN
    logic [3:0] ovf;
`endif

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] mask;
        logic       ack;
        logic [1:0] idx;
        logic [3:0] pend;
        logic       irq;
        logic       busy;
        logic [3:0] ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] row;
        logic [3:0]  pend;
        logic        irq;
        logic        busy;
        logic [3:0]  ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    irq_pending_ctrl #(.HOLDOFF(2), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .ack_idx (ack_idx),
        .pend    (pend),
        .irq     (irq),
        .busy    (busy)
`ifdef IRQ_PENDING_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic [3:0] rq, input logic [3:0] m, input logic a,
                     input logic [1:0] ix, input logic [3:0] ep, input logic ei, input logic eb,
                     input logic [3:0] eo);
        vec_t t;
        t = '{rst:r, req:rq, mask:m, ack:a, idx:ix, pend:ep, irq:ei, busy:eb, ovf:eo};
        vecs.push_back(t);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1; req = '0; mask = '0; ack = 1'b0; ack_idx = '0;

        // Reset, then idle
        v(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        for (int i = 0; i < 10; i++) v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        // Single request, ack, holdoff of 2
        v(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 0, 0, 4'b0000);
        v(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 4'b0000);
        v(0, 4'b0100, 4'b0000, 1, 2, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        // Two simultaneous requests
        v(0, 4'b1010, 4'b0000, 0, 0, 4'b1010, 0, 0, 4'b0000);
        v(0, 4'b1010, 4'b0000, 0, 0, 4'b1010, 1, 1, 4'b0000);
        v(0, 4'b1010, 4'b0000, 1, 3, 4'b0010, 0, 1, 4'b0000);
        v(0, 4'b1010, 4'b0000, 0, 0, 4'b0010, 0, 1, 4'b0000);
        v(0, 4'b1010, 4'b0000, 0, 0, 4'b0010, 0, 0, 4'b0000);
        v(0, 4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 4'b0000);
        v(0, 4'b1010, 4'b0000, 1, 1, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        // Masking, unmask, re-mask in WAIT_ACK
        v(0, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 1, 4'b0000);
        v(0, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 1, 0, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        // Re-edge coinciding with ack, then a merged re-edge
        v(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 0, 0, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0010, 1, 1, 4'b0000);
        v(0, 4'b0010, 4'b0000, 1, 1, 4'b0010, 0, 1, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 1, 4'b0000);
        v(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 0, 0, 4'b0010);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0010, 1, 1, 4'b0010);
        v(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        // Ack naming a non-pending bit
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 1, 3, 4'b0001, 0, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 1, 0, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        // Reset during HOLD, ack while IDLE ignored
        v(0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 0, 0, 4'b0000);
        v(0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 1, 1, 4'b0000);
        v(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 0, 1, 4'b0000);
        v(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0000, 4'b0000, 1, 3, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        // Request high in first cycle after reset is an edge
        v(1, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 0, 0, 4'b0000);
        v(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 4'b0000);
        v(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; mask = vecs[i].mask;
            ack = vecs[i].ack; ack_idx = vecs[i].idx;
            e = '{row:16'(i), pend:vecs[i].pend, irq:vecs[i].irq, busy:vecs[i].busy, ovf:vecs[i].ovf};
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("pend", int'(e.row), 32'(pend), 32'(e.pend));
            check("irq",  int'(e.row), 32'(irq),  32'(e.irq));
            check("busy", int'(e.row), 32'(busy), 32'(e.busy));
`ifdef IRQ_PENDING_OVF_EN
            check("ovf",  int'(e.row), 32'(ovf),  32'(e.ovf));
`endif
        end

        // Latency from request to irq, then holdoff length, with bounded waits
        rst = 1'b0; ack = 1'b0; req = 4'b0001;
        n = 0;
        while (!irq && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("irq_latency", n, 32'(n), 32'd2);
        ack = 1'b1; ack_idx = 2'd0;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("ack_irq_drop", 0, 32'({irq, busy, pend}), 32'({1'b0, 1'b1, 4'b0000}));
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("holdoff_len", n, 32'(n), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
